// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and encodings for the multi-cycle LEGv8 control FSM
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_R,
        S_WB_MEM,
        S_BRANCH,
        S_HALT,
        S_ILLEGAL,
        S_ERROR
    } state_t;

    typedef enum logic [3:0] {
        OP_R,
        OP_I,
        OP_LD,
        OP_ST,
        OP_CBZ,
        OP_CBNZ,
        OP_B,
        OP_HALT,
        OP_ILL
    } opclass_t;

    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADDI = 11'b10010001000;
    localparam logic [10:0] OPC_CBZ  = 11'b10110100000;
    localparam logic [10:0] OPC_CBNZ = 11'b10110101000;
    localparam logic [10:0] OPC_B    = 11'b00010100000;
    localparam logic [10:0] OPC_HALT = 11'b11111111111;

    // Set bits in a mask are compared; cleared bits are operand fields folded into the opcode.
    localparam logic [10:0] MASK_FULL = 11'b11111111111;
    localparam logic [10:0] MASK_ADDI = 11'b11111111110;
    localparam logic [10:0] MASK_CB   = 11'b11111111000;
    localparam logic [10:0] MASK_B    = 11'b11111100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNC  = 2'b10;

    localparam logic [1:0] ALUSRC_REG  = 2'b00;
    localparam logic [1:0] ALUSRC_DIMM = 2'b01;
    localparam logic [1:0] ALUSRC_IIMM = 2'b10;

    function automatic logic op_match(input logic [10:0] inst,
                                      input logic [10:0] pat,
                                      input logic [10:0] mask);
        return ((inst ^ pat) & mask) == 11'b0;
    endfunction

endpackage

// File: rtl/cpu_opclass_decode.sv
// rtl/cpu_opclass_decode.sv - maps the IR opcode field to an instruction class
import cpu_ctrl_pkg::*;

module cpu_opclass_decode (
    input  logic [10:0] inst31_21,
    output opclass_t    opclass
);

    always_comb begin
        opclass = OP_ILL;
        if (op_match(inst31_21, OPC_LDUR, MASK_FULL)) begin
            opclass = OP_LD;
        end else if (op_match(inst31_21, OPC_STUR, MASK_FULL)) begin
            opclass = OP_ST;
        end else if (op_match(inst31_21, OPC_ADD, MASK_FULL)
                  || op_match(inst31_21, OPC_SUB, MASK_FULL)
                  || op_match(inst31_21, OPC_AND, MASK_FULL)
                  || op_match(inst31_21, OPC_ORR, MASK_FULL)) begin
            opclass = OP_R;
        end else if (op_match(inst31_21, OPC_ADDI, MASK_ADDI)) begin
            opclass = OP_I;
        end else if (op_match(inst31_21, OPC_CBZ, MASK_CB)) begin
            opclass = OP_CBZ;
        end else if (op_match(inst31_21, OPC_CBNZ, MASK_CB)) begin
            opclass = OP_CBNZ;
        end else if (op_match(inst31_21, OPC_B, MASK_B)) begin
            opclass = OP_B;
        end else if (op_match(inst31_21, OPC_HALT, MASK_FULL)) begin
            opclass = OP_HALT;
        end
    end

endmodule

// File: rtl/cpu_multicycle_control.sv
// rtl/cpu_multicycle_control.sv - multi-cycle control FSM with memory handshake, timeout and retire count
import cpu_ctrl_pkg::*;

module cpu_multicycle_control #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      inst31_21,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             Reg2Loc,
    output logic [1:0]       ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             halted,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

    state_t             state_q, state_d;
    opclass_t           op_q, op_d;
    opclass_t           dec_class;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire_inc;
    logic               wait_expired;
    logic               br_taken;

    cpu_opclass_decode u_decode (
        .inst31_21 (inst31_21),
        .opclass   (dec_class)
    );

    // The limit is checked on the cycle the count already equals TIMEOUT, so a
    // ready arriving in that cycle still completes the access.
    assign wait_expired = (TIMEOUT != 0) && (wait_cnt_q == WAIT_LIMIT);

    assign br_taken = (op_q == OP_B)
                   || ((op_q == OP_CBZ)  &&  zero)
                   || ((op_q == OP_CBNZ) && !zero);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_cnt_d = '0;
        retire_inc = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        Reg2Loc    = 1'b0;
        ALUSrc     = ALUSRC_REG;
        ALUOp      = ALUOP_ADD;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;

        case (state_q)
            S_INIT: state_d = S_FETCH;

            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_DECODE: begin
                op_d = dec_class;
                case (dec_class)
                    OP_LD, OP_ST:            state_d = S_ADDR;
                    OP_R:                    state_d = S_EXEC_R;
                    OP_I:                    state_d = S_EXEC_I;
                    OP_CBZ, OP_CBNZ, OP_B:   state_d = S_BRANCH;
                    OP_HALT:                 state_d = S_HALT;
                    default:                 state_d = S_ILLEGAL;
                endcase
            end

            S_EXEC_R: begin
                ALUOp   = ALUOP_FUNC;
                ALUSrc  = ALUSRC_REG;
                state_d = S_WB_R;
            end

            S_EXEC_I: begin
                ALUOp   = ALUOP_FUNC;
                ALUSrc  = ALUSRC_IIMM;
                state_d = S_WB_R;
            end

            S_WB_R: begin
                RegWrite   = 1'b1;
                retire_inc = 1'b1;
                state_d    = S_FETCH;
            end

            S_ADDR: begin
                ALUOp   = ALUOP_ADD;
                ALUSrc  = ALUSRC_DIMM;
                Reg2Loc = (op_q == OP_ST);
                state_d = (op_q == OP_ST) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                mem_read = 1'b1;
                ALUOp    = ALUOP_ADD;
                ALUSrc   = ALUSRC_DIMM;
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_MEM_WR: begin
                mem_write = 1'b1;
                Reg2Loc   = 1'b1;
                ALUOp     = ALUOP_ADD;
                ALUSrc    = ALUSRC_DIMM;
                if (mem_ready) begin
                    retire_inc = 1'b1;
                    state_d    = S_FETCH;
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_WB_MEM: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                retire_inc = 1'b1;
                state_d    = S_FETCH;
            end

            S_BRANCH: begin
                if (op_q != OP_B) begin
                    Reg2Loc = 1'b1;
                    ALUOp   = ALUOP_PASSB;
                    ALUSrc  = ALUSRC_REG;
                end
                pc_write   = br_taken;
                pc_src     = br_taken;
                retire_inc = 1'b1;
                state_d    = S_FETCH;
            end

            S_HALT:    halted  = 1'b1;
            S_ILLEGAL: illegal = 1'b1;
            S_ERROR:   mem_err = 1'b1;
            default:   state_d = S_INIT;
        endcase

        retired_d = retire_inc ? (retired_q + CNT_W'(1)) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_INIT;
            op_q       <= OP_ILL;
            wait_cnt_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_cpu_multicycle_control.sv
// tb/tb_cpu_multicycle_control.sv - directed self-checking bench for cpu_multicycle_control
module tb_cpu_multicycle_control;

    logic        clk;
    logic        reset;
    logic [10:0] inst31_21;
    logic        zero;
    logic        mem_ready;
    logic        mem_read, mem_write, ir_write, pc_write, pc_src, Reg2Loc;
    logic [1:0]  ALUSrc, ALUOp;
    logic        MemtoReg, RegWrite, halted, illegal, mem_err;
    logic [3:0]  retired;

    cpu_multicycle_control #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .inst31_21 (inst31_21),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .Reg2Loc   (Reg2Loc),
        .ALUSrc    (ALUSrc),
        .ALUOp     (ALUOp),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .halted    (halted),
        .illegal   (illegal),
        .mem_err   (mem_err),
        .retired   (retired)
    );

    localparam logic [10:0] I_ADD  = 11'b10001011000;
    localparam logic [10:0] I_SUB  = 11'b11001011000;
    localparam logic [10:0] I_AND  = 11'b10001010000;
    localparam logic [10:0] I_ORR  = 11'b10101010000;
    localparam logic [10:0] I_ADDI = 11'b10010001001;
    localparam logic [10:0] I_LDUR = 11'b11111000010;
    localparam logic [10:0] I_STUR = 11'b11111000000;
    localparam logic [10:0] I_CBZ  = 11'b10110100101;
    localparam logic [10:0] I_CBNZ = 11'b10110101011;
    localparam logic [10:0] I_B    = 11'b00010110110;
    localparam logic [10:0] I_HALT = 11'b11111111111;

    logic [14:0] ctrl;
    assign ctrl = {mem_read, mem_write, ir_write, pc_write, pc_src, Reg2Loc,
                   ALUSrc, ALUOp, MemtoReg, RegWrite, halted, illegal, mem_err};

    int         checks;
    int         failures;
    logic [3:0] exp_ret;

    logic [14:0] C_ZERO, C_F_WAIT, C_F_RDY, C_EXEC_R, C_EXEC_I, C_WB_R, C_ADDR_LD, C_ADDR_ST;
    logic [14:0] C_MEM_RD, C_MEM_WR, C_WB_MEM, C_CB_T, C_CB_N, C_B, C_HALT, C_ILL, C_ERR;

    function automatic logic [14:0] mk(input logic mr, input logic mw, input logic irw,
                                       input logic pcw, input logic pcs, input logic r2l,
                                       input logic [1:0] src, input logic [1:0] op,
                                       input logic m2r, input logic rw, input logic h,
                                       input logic il, input logic me);
        return {mr, mw, irw, pcw, pcs, r2l, src, op, m2r, rw, h, il, me};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input string tag, input logic [14:0] exp);
        #1;
        check_eq(tag, {17'b0, ctrl}, {17'b0, exp});
        tick();
    endtask

    task automatic chk_ret(input string tag);
        check_eq(tag, {28'b0, retired}, {28'b0, exp_ret});
    endtask

    task automatic fetch_dec(input logic [10:0] op);
        inst31_21 = op;
        mem_ready = 1'b1;
        cyc("fetch", C_F_RDY);
        mem_ready = 1'b0;
        cyc("decode", C_ZERO);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        #1;
        check_eq("rst_ctrl", {17'b0, ctrl}, 32'd0);
        check_eq("rst_retired", {28'b0, retired}, 32'd0);
        reset = 1'b0;
        cyc("init", C_ZERO);
        exp_ret = 4'd0;
    endtask

    task automatic rtype(input logic [10:0] op, input logic [14:0] exec_exp);
        fetch_dec(op);
        cyc("exec", exec_exp);
        cyc("wb_r", C_WB_R);
        exp_ret++;
        chk_ret("ret_rtype");
    endtask

    task automatic branch(input logic [10:0] op, input logic z, input logic [14:0] exp);
        fetch_dec(op);
        zero = z;
        inst31_21 = I_HALT;
        cyc("branch", exp);
        zero = 1'b0;
        exp_ret++;
        chk_ret("ret_branch");
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_ret   = 4'd0;
        reset     = 1'b1;
        zero      = 1'b0;
        mem_ready = 1'b0;
        inst31_21 = 11'b0;

        C_ZERO    = 15'b0;
        C_F_WAIT  = mk(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0,0);
        C_F_RDY   = mk(1,0,1,1,0,0,2'b00,2'b00,0,0,0,0,0);
        C_EXEC_R  = mk(0,0,0,0,0,0,2'b00,2'b10,0,0,0,0,0);
        C_EXEC_I  = mk(0,0,0,0,0,0,2'b10,2'b10,0,0,0,0,0);
        C_WB_R    = mk(0,0,0,0,0,0,2'b00,2'b00,0,1,0,0,0);
        C_ADDR_LD = mk(0,0,0,0,0,0,2'b01,2'b00,0,0,0,0,0);
        C_ADDR_ST = mk(0,0,0,0,0,1,2'b01,2'b00,0,0,0,0,0);
        C_MEM_RD  = mk(1,0,0,0,0,0,2'b01,2'b00,0,0,0,0,0);
        C_MEM_WR  = mk(0,1,0,0,0,1,2'b01,2'b00,0,0,0,0,0);
        C_WB_MEM  = mk(0,0,0,0,0,0,2'b00,2'b00,1,1,0,0,0);
        C_CB_T    = mk(0,0,0,1,1,1,2'b00,2'b01,0,0,0,0,0);
        C_CB_N    = mk(0,0,0,0,0,1,2'b00,2'b01,0,0,0,0,0);
        C_B       = mk(0,0,0,1,1,0,2'b00,2'b00,0,0,0,0,0);
        C_HALT    = mk(0,0,0,0,0,0,2'b00,2'b00,0,0,1,0,0);
        C_ILL     = mk(0,0,0,0,0,0,2'b00,2'b00,0,0,0,1,0);
        C_ERR     = mk(0,0,0,0,0,0,2'b00,2'b00,0,0,0,0,1);

        tick();
        do_reset();

        rtype(I_ADD, C_EXEC_R);

        fetch_dec(I_LDUR);
        mem_ready = 1'b1;
        cyc("addr_ld", C_ADDR_LD);
        mem_ready = 1'b0;
        repeat (3) cyc("mem_rd_wait", C_MEM_RD);
        mem_ready = 1'b1;
        cyc("mem_rd_rdy", C_MEM_RD);
        mem_ready = 1'b0;
        cyc("wb_mem", C_WB_MEM);
        exp_ret++;
        chk_ret("ret_ldur");

        fetch_dec(I_STUR);
        cyc("addr_st", C_ADDR_ST);
        mem_ready = 1'b1;
        cyc("mem_wr", C_MEM_WR);
        exp_ret++;
        chk_ret("ret_stur");

        branch(I_CBZ,  1'b1, C_CB_T);
        branch(I_CBZ,  1'b0, C_CB_N);
        branch(I_CBNZ, 1'b1, C_CB_N);
        branch(I_CBNZ, 1'b0, C_CB_T);
        branch(I_B,    1'b0, C_B);
        branch(I_B,    1'b1, C_B);

        rtype(I_ADDI, C_EXEC_I);
        rtype(I_SUB,  C_EXEC_R);
        rtype(I_AND,  C_EXEC_R);
        rtype(I_ORR,  C_EXEC_R);

        repeat (3) branch(I_B, 1'b0, C_B);
        check_eq("ret_wrap", {28'b0, retired}, 32'd0);

        fetch_dec(I_HALT);
        repeat (20) cyc("halt", C_HALT);
        chk_ret("ret_halt_frozen");

        do_reset();
        fetch_dec(11'b00000000000);
        repeat (3) cyc("illegal", C_ILL);

        do_reset();
        fetch_dec(11'b11111000001);
        cyc("illegal_near_ldur", C_ILL);

        do_reset();
        fetch_dec(I_LDUR);
        cyc("addr_ld2", C_ADDR_LD);
        repeat (2) cyc("mem_rd_wait2", C_MEM_RD);
        do_reset();

        inst31_21 = I_ADD;
        mem_ready = 1'b0;
        repeat (4) cyc("fetch_wait", C_F_WAIT);
        mem_ready = 1'b1;
        cyc("fetch_tie", C_F_RDY);
        mem_ready = 1'b0;
        cyc("decode_tie", C_ZERO);
        cyc("exec_tie", C_EXEC_R);
        cyc("wb_tie", C_WB_R);
        exp_ret++;
        chk_ret("ret_tie");

        repeat (4) cyc("fetch_wait_to", C_F_WAIT);
        tick();
        mem_ready = 1'b1;
        repeat (3) cyc("error", C_ERR);
        chk_ret("ret_error_held");
        mem_ready = 1'b0;
        do_reset();
        cyc("fetch_after_err", C_F_WAIT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
